// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO
//   registers. It sits beside the ALU in the execute stage and shares the
//   alu_op/A/B operand buses. The controller stalls while busy is high.
//
//   MULT/MULTU : shift-add, one multiplier bit per cycle, W cycles, then a fix-up
//                cycle that applies the sign and writes {hi,lo}.
//   DIV/DIVU   : restoring division, one quotient bit per cycle, W cycles, then
//                the fix-up cycle writes lo=quotient and hi=remainder.
//   MTHI/MTLO  : single-cycle write of A into hi/lo. These ops are only
//                accepted while idle.
//   MFHI/MFLO  : purely combinational reads through mf_data.
//
//   W must be even and at least 4.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request strobe, sampled only while idle
//   alu_op   in   funct code, sampled together with start
//   A, B     in   rs / rt operands
//   busy     out  high while an iterative op is in flight
//   done     out  one-cycle pulse after HI/LO are written by MULT/DIV
//   hi, lo   out  current HI / LO registers
//   mf_data  out  hi for MFHI, lo for MFLO, otherwise 0
// -----------------------------------------------------------------------------
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 6
`endif

module muldiv_unit #(
  parameter int W = `W_CPU
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [`W_OPCODE-1:0] alu_op,
  input  logic [W-1:0]         A,
  input  logic [W-1:0]         B,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         hi,
  output logic [W-1:0]         lo,
  output logic [W-1:0]         mf_data
);

  localparam logic [`W_OPCODE-1:0] F_MFHI  = `W_OPCODE'(6'h10);
  localparam logic [`W_OPCODE-1:0] F_MTHI  = `W_OPCODE'(6'h11);
  localparam logic [`W_OPCODE-1:0] F_MFLO  = `W_OPCODE'(6'h12);
  localparam logic [`W_OPCODE-1:0] F_MTLO  = `W_OPCODE'(6'h13);
  localparam logic [`W_OPCODE-1:0] F_MULT  = `W_OPCODE'(6'h18);
  localparam logic [`W_OPCODE-1:0] F_MULTU = `W_OPCODE'(6'h19);
  localparam logic [`W_OPCODE-1:0] F_DIV   = `W_OPCODE'(6'h1a);
  localparam logic [`W_OPCODE-1:0] F_DIVU  = `W_OPCODE'(6'h1b);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*W-1:0] acc_reg;     // MUL: {partial product, remaining multiplier}
                               // DIV: {partial remainder, dividend/quotient}
  logic [W-1:0]   opb_reg;     // multiplicand or divisor magnitude
  logic           is_div_reg;
  logic           neg_lo_reg;  // negate product (MUL) or quotient (DIV)
  logic           neg_hi_reg;  // negate remainder (DIV only)
  logic           busy_reg;
  logic           done_reg;
  logic [W-1:0]   hi_reg;
  logic [W-1:0]   lo_reg;

  // Operand decode and magnitude extraction
  logic         op_mul_any;
  logic         op_div_any;
  logic         op_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign op_mul_any = (alu_op == F_MULT) || (alu_op == F_MULTU);
  assign op_div_any = (alu_op == F_DIV)  || (alu_op == F_DIVU);
  assign op_signed  = (alu_op == F_MULT) || (alu_op == F_DIV);
  assign a_neg      = op_signed & A[W-1];
  assign b_neg      = op_signed & B[W-1];
  // The most negative value maps onto itself, which is the right unsigned
  // magnitude (2^(W-1)).
  assign a_mag      = a_neg ? (~A + W'(1)) : A;
  assign b_mag      = b_neg ? (~B + W'(1)) : B;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[W-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and try
  // to subtract. A zero divisor always "succeeds", which naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  assign div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
  assign div_diff  = div_shift - {1'b0, opb_reg};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc_reg[W-2:0], 1'b1};

  // Sign fix-up applied in FIX
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  assign prod_fix = neg_lo_reg ? (~acc_reg + (2*W)'(1)) : acc_reg;
  assign quo_fix  = neg_lo_reg ? (~acc_reg[W-1:0] + W'(1)) : acc_reg[W-1:0];
  assign rem_fix  = neg_hi_reg ? (~acc_reg[2*W-1:W] + W'(1)) : acc_reg[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (op_mul_any) begin
              acc_reg    <= {{W{1'b0}}, b_mag};
              opb_reg    <= a_mag;
              neg_lo_reg <= a_neg ^ b_neg;
              neg_hi_reg <= 1'b0;
              is_div_reg <= 1'b0;
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= S_MUL;
            end else if (op_div_any) begin
              acc_reg    <= {{W{1'b0}}, a_mag};
              opb_reg    <= b_mag;
              neg_lo_reg <= a_neg ^ b_neg;
              neg_hi_reg <= a_neg;
              is_div_reg <= 1'b1;
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= S_DIV;
            end else if (alu_op == F_MTHI) begin
              hi_reg <= A;
            end else if (alu_op == F_MTLO) begin
              lo_reg <= A;
            end
          end
        end
        S_MUL: begin
          acc_reg <= mul_next;
          if (cnt_reg == CW'(W - 1)) begin
            cnt_reg   <= '0;
            state_reg <= S_FIX;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_DIV: begin
          acc_reg <= div_next;
          if (cnt_reg == CW'(W - 1)) begin
            cnt_reg   <= '0;
            state_reg <= S_FIX;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*W-1:W];
            lo_reg <= prod_fix[W-1:0];
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mf_data = '0;
    if (alu_op == F_MFHI)      mf_data = hi_reg;
    else if (alu_op == F_MFLO) mf_data = lo_reg;
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
